ad9361_spi_responder: RTL and testbench
=======================================

# ad9361_spi_responder

Synthesizable responder for the AD9361 4-wire SPI protocol. It acts as the chip end of the link: it decodes 24-bit instruction/data frames from an SPI master, such as the AD9361 init sequencer, and holds a 1024 x 8 shadow register file. It answers reads on MISO and reports every committed write on a strobe interface. It runs on the 200 MHz system clock and oversamples the SPI lines, so it can stand in for the transceiver in loopback builds and system benches.

## Interface
Parameters:
- ADDR_W, 10, register address width; the register file is 2^ADDR_W bytes.
- SYNC_STAGES, 2, synchronizer depth on spi_csn, spi_clk and spi_mosi.

Ports:
- sys_clk_200  in  1  system clock; all logic is on this clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- spi_csn  in  1  chip select, active-low, asynchronous to sys_clk_200.
- spi_clk  in  1  SPI clock, CPOL=0.
- spi_mosi  in  1  serial data from the master, MSB first.
- spi_miso  out  1  serial read data to the master.
- spi_miso_oe  out  1  high while the responder drives read data.
- wr_stb  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  ADDR_W  address of the committed write.
- wr_data  out  8  data of the committed write.
- rd_stb  out  1  one-cycle pulse when a register is fetched for readback.
- frame_err  out  1  one-cycle pulse when a frame is aborted or unsupported.

## Operation
- Frame format (24 bits, MSB first):
  - bit 23: W/Rb (1 = write).
  - bits 22:20: NB, the byte count minus 1.
  - bits 19:18: don't care.
  - bits 17:8: address.
  - bits 7:0: data.
- Edge timing:
  - The master changes MOSI after SCLK falling edges; the responder samples MOSI on SCLK rising edges.
  - The responder changes MISO after SCLK falling edges.
- Edge detection: synchronized spi_clk and spi_csn are edge-detected (prev vs. current register).
- State machine:
  - IDLE -> INSTR on the synchronized csn falling edge; the bit counter clears.
  - INSTR: shift 16 bits. On the 16th rising edge, latch rw, nb and addr. For a read, fetch reg[addr], load the MISO shift register and pulse rd_stb. Then go to DATA.
  - DATA: shift 8 bits. For a write, on the 8th rising edge write reg[addr], pulse wr_stb with wr_addr/wr_data, and go to DONE.
  - DONE: ignore all edges until csn rises, then go to IDLE.
- Read data path:
  - spi_miso_oe is high from the falling edge after instruction bit 16 until csn rises.
  - spi_miso shifts out bit 7 first, one bit per falling edge.
  - While oe is low, spi_miso = 0.
- Abort: csn rising in INSTR or DATA returns to IDLE with no write and pulses frame_err.
  - Exception: csn rising with zero bits shifted is not an error.
- NB != 0 is handled as described under Configuration.
- Reset values:
  - State IDLE; all shift registers and counters 0.
  - spi_miso = 0, spi_miso_oe = 0, wr_stb = 0, rd_stb = 0, frame_err = 0.
  - wr_addr = 0, wr_data = 0.
  - All register-file bytes 0.
- Reset mid-frame: the frame is discarded; the responder resynchronizes on the next csn falling edge.

## Timing
- Synchronizer plus edge-detect latency: SYNC_STAGES+1 cycles from a pin edge to internal action.
- wr_stb asserts SYNC_STAGES+2 cycles after the 24th SCLK rising edge at the pin.
- Readback fetch takes 1 cycle after the 16th rising edge is detected. MISO bit 7 is valid SYNC_STAGES+2 cycles after the 16th falling edge.
- Each SCLK half-period must be at least 6 sys_clk_200 cycles (SCLK <= 16.6 MHz). The bench must not violate this, and the design does not check it.
- wr_stb, rd_stb and frame_err are mutually exclusive within a cycle and never wider than 1 cycle.

## Configuration
- AD9361_SPI_RESP_MULTIBYTE_EN defined:
  - NB+1 data bytes are transferred in one frame.
  - After each byte, the address decrements, wrapping 0 -> 2^ADDR_W-1.
  - Each write byte produces its own wr_stb.
  - Each read byte refetches on the 8th rising edge of the previous byte.
  - Go to DONE after byte NB.
- Undefined:
  - A frame with NB != 0 transfers only the first byte.
  - frame_err pulses after that byte, then the state goes to DONE.

## Structure
- Package ad9361_spi_pkg:
  - state enum (IDLE, INSTR, DATA, DONE).
  - INSTR_BITS=16, DATA_BITS=8.
  - Bit-position constants for W/Rb, NB and address.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizer plus rise/fall detect for one pin. It is instantiated three times.

## Test plan
- Write 0x0AA, data 0x5C (frame 0x80AA5C) -> one wr_stb with wr_addr=0x0AA, wr_data=0x5C; no frame_err.
- Read 0x0AA after the above (frame 0x00AA00) -> rd_stb once; the master captures 0x5C on MISO; spi_miso_oe falls on csn rise.
- Read a never-written address 0x3FF -> MISO returns 0x00.
- csn rises after 12 bits -> frame_err pulse, no wr_stb; the next valid write 0x8001FF commits addr 0x001, data 0xFF.
- Write with NB=1 to addr 0x000, bytes 0x11, 0x22:
  - With the macro: writes 0x000 = 0x11 and 0x3FF = 0x22 (wrap).
  - Without the macro: only 0x000 = 0x11 is written, plus a frame_err pulse.
- Assert sys_rst during DATA of a write -> no wr_stb; all outputs return to reset values; the next frame decodes correctly.

Source files
------------

// File: rtl/ad9361_spi_responder_pkg.sv
// Shared types and frame-layout constants for the AD9361 SPI responder.
package ad9361_spi_pkg;

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  localparam int INSTR_BITS = 16;
  localparam int DATA_BITS  = 8;

  // Bit positions within the 24-bit frame, MSB first on the wire.
  localparam int FRAME_RW_BIT   = 23;
  localparam int FRAME_NB_MSB   = 22;
  localparam int FRAME_NB_LSB   = 20;
  localparam int FRAME_ADDR_MSB = 17;
  localparam int FRAME_ADDR_LSB = 8;

endpackage

// File: rtl/ad9361_spi_responder_if.sv
// Four-wire SPI link between an AD9361-style master and the responder.
interface ad9361_spi_responder_if;
  logic spi_csn;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_csn, spi_clk, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave  (input spi_csn, spi_clk, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/ad9361_spi_responder_pin_sync.sv
// Multi-stage synchronizer plus rise/fall detection for one asynchronous pin.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/ad9361_spi_responder.sv
// AD9361 4-wire SPI responder: oversampled frame decoder with a shadow register file.
// Optional AD9361_SPI_RESP_MULTIBYTE_EN enables NB+1 byte frames with decrementing address.
module ad9361_spi_responder
  import ad9361_spi_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk_200,
  input  logic                  sys_rst,
  ad9361_spi_responder_if.slave spi,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_stb,
  output logic                  frame_err
);
  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [3:0] INSTR_LAST = 4'(INSTR_BITS - 1);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS - 1);
  localparam int         RW_POS     = FRAME_RW_BIT - DATA_BITS;
  localparam int         NB_MSB     = FRAME_NB_MSB - DATA_BITS;
  localparam int         NB_LSB     = FRAME_NB_LSB - DATA_BITS;

  logic csn_lvl, csn_rise, csn_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // csn idles high, so its synchronizer resets high to avoid a false frame start.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(sys_clk_200), .rst(sys_rst), .pin(spi.spi_csn),
    .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(sys_clk_200), .rst(sys_rst), .pin(spi.spi_clk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(sys_clk_200), .rst(sys_rst), .pin(spi.spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  state_t                  state;
  logic [3:0]              bit_cnt;
  logic [INSTR_BITS-2:0]   instr_sr;
  logic [DATA_BITS-2:0]    data_sr;
  logic                    rw;
  logic [2:0]              nb;
  logic [ADDR_W-1:0]       addr;
  logic [7:0]              miso_sr;
  logic                    miso_q;
  logic                    oe_q;
  logic                    err_pend;
  logic [7:0]              mem [DEPTH];
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
  logic [2:0]              byte_cnt;
`endif

  logic [INSTR_BITS-1:0] instr_word;
  logic [7:0]            data_byte;
  assign instr_word = {instr_sr, mosi_lvl};
  assign data_byte  = {data_sr, mosi_lvl};

  logic unused_sync;
  assign unused_sync = ^{csn_lvl, sclk_lvl, mosi_rise, mosi_fall,
                         instr_word[NB_LSB-1:FRAME_ADDR_MSB+1-DATA_BITS]};

  always_ff @(posedge sys_clk_200 or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      instr_sr  <= '0;
      data_sr   <= '0;
      rw        <= 1'b0;
      nb        <= '0;
      addr      <= '0;
      miso_sr   <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      err_pend  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
      byte_cnt  <= '0;
`endif
      // NOTE: the shadow file must read back zero after reset, so it is built
      // from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= err_pend;
      err_pend  <= 1'b0;

      case (state)
        IDLE: begin
          if (csn_fall) begin
            state   <= INSTR;
            bit_cnt <= '0;
          end
        end

        INSTR, DATA: begin
          if (csn_rise) begin
            // A select pulse with no clocks at all is benign; anything else is a truncated frame.
            state  <= IDLE;
            oe_q   <= 1'b0;
            miso_q <= 1'b0;
            if (state == DATA || bit_cnt != '0) frame_err <= 1'b1;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (state == INSTR) begin
              instr_sr <= instr_word[INSTR_BITS-2:0];
              if (bit_cnt == INSTR_LAST) begin
                rw      <= instr_word[RW_POS];
                nb      <= instr_word[NB_MSB:NB_LSB];
                addr    <= instr_word[ADDR_W-1:0];
                bit_cnt <= '0;
                state   <= DATA;
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
                byte_cnt <= '0;
`endif
                if (!instr_word[RW_POS]) begin
                  miso_sr <= mem[instr_word[ADDR_W-1:0]];
                  rd_stb  <= 1'b1;
                end
              end
            end else begin
              data_sr <= data_byte[DATA_BITS-2:0];
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (rw) begin
                  mem[addr] <= data_byte;
                  wr_stb    <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= data_byte;
                end
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
                if (byte_cnt == nb) begin
                  state <= DONE;
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                  addr     <= addr - 1'b1;
                  if (!rw) begin
                    miso_sr <= mem[addr - 1'b1];
                    rd_stb  <= 1'b1;
                  end
                end
`else
                // Delayed one cycle so it never coincides with wr_stb/rd_stb.
                err_pend <= (nb != '0);
                state    <= DONE;
`endif
              end
            end
          end else if (sclk_fall && state == DATA && !rw) begin
            oe_q              <= 1'b1;
            {miso_q, miso_sr} <= {miso_sr, 1'b0};
          end
        end

        DONE: begin
          if (csn_rise) begin
            state  <= IDLE;
            oe_q   <= 1'b0;
            miso_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
endmodule

// File: tb/tb_ad9361_spi_responder.sv
// Randomized bench for ad9361_spi_responder against a byte-array model of the register file.
module tb_ad9361_spi_responder;
  localparam int HALF = 8;

  logic       sys_clk_200 = 1'b0;
  logic       sys_rst;
  logic       wr_stb, rd_stb, frame_err;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  ad9361_spi_responder_if spi ();

  ad9361_spi_responder #(.ADDR_W(10), .SYNC_STAGES(2)) dut (
    .sys_clk_200(sys_clk_200),
    .sys_rst    (sys_rst),
    .spi        (spi),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_stb     (rd_stb),
    .frame_err  (frame_err)
  );

  always #5 sys_clk_200 = ~sys_clk_200;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem [1024];

  // Strobe monitor: counts pulses, logs writes, flags overlap or stretched pulses.
  int          wr_cnt, rd_cnt, err_cnt, viol_cnt;
  logic [17:0] wr_log [$];
  logic        prev_wr = 1'b0, prev_rd = 1'b0, prev_err = 1'b0;

  always @(negedge sys_clk_200) begin
    if (wr_stb === 1'b1) begin
      wr_cnt++;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (rd_stb === 1'b1) rd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if ((int'(wr_stb) + int'(rd_stb) + int'(frame_err)) > 1 ||
        (wr_stb && prev_wr) || (rd_stb && prev_rd) || (frame_err && prev_err))
      viol_cnt++;
    prev_wr  = wr_stb;
    prev_rd  = rd_stb;
    prev_err = frame_err;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] mk_hdr(input logic rw, input int nb, input int dc, input int addr);
    logic [2:0] nb3;
    logic [1:0] dc2;
    logic [9:0] a10;
    nb3 = nb[2:0];
    dc2 = dc[1:0];
    a10 = addr[9:0];
    return {rw, nb3, dc2, a10};
  endfunction

  function automatic logic [127:0] mk_frame(input logic [15:0] hdr, input logic [63:0] data);
    return {hdr, data, 48'h0};
  endfunction

  task automatic clr_mon;
    wr_cnt  = 0;
    rd_cnt  = 0;
    err_cnt = 0;
    wr_log.delete();
  endtask

  task automatic csn_release;
    spi.spi_csn  = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge sys_clk_200);
  endtask

  // Mode-0 master: MOSI set while SCLK is low, MISO captured just before each rise.
  task automatic spi_bits(input logic [127:0] tx, input int nbits, input bit release_csn,
                          output logic [127:0] rx);
    rx = '0;
    spi.spi_csn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi = tx[127-i];
      repeat (HALF) @(negedge sys_clk_200);
      rx[127-i] = spi.spi_miso;
      spi.spi_clk = 1'b1;
      repeat (HALF) @(negedge sys_clk_200);
      spi.spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge sys_clk_200);
    if (release_csn) csn_release();
  endtask

  task automatic test_reset;
    logic [23:0] outs;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    sys_rst      = 1'b1;
    spi.spi_csn  = 1'b1;
    spi.spi_clk  = 1'b0;
    spi.spi_mosi = 1'b0;
    repeat (5) @(negedge sys_clk_200);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk_200);
    outs = {spi.spi_miso, spi.spi_miso_oe, wr_stb, rd_stb, frame_err, 1'b0, wr_addr, wr_data};
    tests_run++;
    if (outs[23:19] !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: miso/oe/wr/rd/err got %b expected 00000", outs[23:19]);
    end
    tests_run++;
    if (wr_addr !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_wr_addr: got %h expected 000", wr_addr);
    end
    tests_run++;
    if (wr_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_wr_data: got %h expected 00", wr_data);
    end
  endtask

  task automatic test_write_read;
    logic [127:0] rx;
    logic [17:0]  got;
    clr_mon();
    spi_bits({24'h80AA5C, 104'h0}, 24, 1'b1, rx);
    ref_mem[10'h0AA] = 8'h5C;
    got = (wr_log.size() > 0) ? wr_log[0] : 18'bx;
    tests_run++;
    if (wr_cnt !== 1) begin
      tests_failed++;
      $display("FAIL wr_count: got %0d expected 1", wr_cnt);
    end
    tests_run++;
    if (got !== {10'h0AA, 8'h5C}) begin
      tests_failed++;
      $display("FAIL wr_payload: got addr %h data %h expected addr 0aa data 5c", got[17:8], got[7:0]);
    end
    tests_run++;
    if (err_cnt !== 0 || rd_cnt !== 0) begin
      tests_failed++;
      $display("FAIL wr_side_strobes: err %0d rd %0d expected 0 0", err_cnt, rd_cnt);
    end

    clr_mon();
    spi_bits({24'h00AA00, 104'h0}, 24, 1'b0, rx);
    tests_run++;
    if (spi.spi_miso_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_oe_active: got %b expected 1", spi.spi_miso_oe);
    end
    csn_release();
    tests_run++;
    if (spi.spi_miso_oe !== 1'b0 || spi.spi_miso !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_oe_release: oe %b miso %b expected 0 0", spi.spi_miso_oe, spi.spi_miso);
    end
    tests_run++;
    if (rd_cnt !== 1) begin
      tests_failed++;
      $display("FAIL rd_count: got %0d expected 1", rd_cnt);
    end
    tests_run++;
    if (rx[111:104] !== 8'h5C) begin
      tests_failed++;
      $display("FAIL rd_data_0aa: got %h expected 5c", rx[111:104]);
    end

    clr_mon();
    spi_bits({24'h03FF00, 104'h0}, 24, 1'b1, rx);
    tests_run++;
    if (rx[111:104] !== 8'h00) begin
      tests_failed++;
      $display("FAIL rd_unwritten_3ff: got %h expected 00", rx[111:104]);
    end
  endtask

  task automatic test_abort;
    logic [127:0] rx;
    logic [17:0]  got;
    clr_mon();
    spi.spi_csn = 1'b0;
    repeat (2 * HALF) @(negedge sys_clk_200);
    csn_release();
    tests_run++;
    if (err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL empty_select: frame_err pulses %0d expected 0", err_cnt);
    end

    clr_mon();
    spi_bits({24'h80AA77, 104'h0}, 12, 1'b1, rx);
    tests_run++;
    if (err_cnt !== 1 || wr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_instr: err %0d wr %0d expected 1 0", err_cnt, wr_cnt);
    end

    clr_mon();
    spi_bits({24'h80AA77, 104'h0}, 20, 1'b1, rx);
    tests_run++;
    if (err_cnt !== 1 || wr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_data: err %0d wr %0d expected 1 0", err_cnt, wr_cnt);
    end

    clr_mon();
    spi_bits({24'h8001FF, 104'h0}, 24, 1'b1, rx);
    ref_mem[10'h001] = 8'hFF;
    got = (wr_log.size() > 0) ? wr_log[0] : 18'bx;
    tests_run++;
    if (wr_cnt !== 1 || got !== {10'h001, 8'hFF} || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL post_abort_write: wr %0d addr %h data %h err %0d expected 1 001 ff 0",
               wr_cnt, got[17:8], got[7:0], err_cnt);
    end
  endtask

  task automatic test_multibyte;
    logic [127:0] rx;
    logic [17:0]  got0, got1;
    clr_mon();
    spi_bits({32'h9000_1122, 96'h0}, 32, 1'b1, rx);
    got0 = (wr_log.size() > 0) ? wr_log[0] : 18'bx;
    got1 = (wr_log.size() > 1) ? wr_log[1] : 18'bx;
    tests_run++;
    if (got0 !== {10'h000, 8'h11}) begin
      tests_failed++;
      $display("FAIL mb_first_byte: got addr %h data %h expected 000 11", got0[17:8], got0[7:0]);
    end
    ref_mem[10'h000] = 8'h11;
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
    ref_mem[10'h3FF] = 8'h22;
    tests_run++;
    if (wr_cnt !== 2 || got1 !== {10'h3FF, 8'h22} || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL mb_wrap_byte: wr %0d addr %h data %h err %0d expected 2 3ff 22 0",
               wr_cnt, got1[17:8], got1[7:0], err_cnt);
    end
`else
    tests_run++;
    if (wr_cnt !== 1 || err_cnt !== 1) begin
      tests_failed++;
      $display("FAIL mb_truncate: wr %0d err %0d expected 1 1 (second byte %h)", wr_cnt, err_cnt, got1);
    end
`endif
    clr_mon();
    spi_bits({24'h03FF00, 104'h0}, 24, 1'b1, rx);
    tests_run++;
    if (rx[111:104] !== ref_mem[10'h3FF]) begin
      tests_failed++;
      $display("FAIL mb_readback_3ff: got %h expected %h", rx[111:104], ref_mem[10'h3FF]);
    end
  endtask

  task automatic test_random;
    logic [127:0] rx;
    logic [63:0]  data;
    logic [15:0]  hdr;
    logic [17:0]  exp_log [$];
    logic [7:0]   exp_rx [$];
    logic [17:0]  got;
    logic [9:0]   a10;
    logic [7:0]   b;
    int rw, nb, r, addr, a, nbytes, exp_wr, exp_rd, exp_err;
    for (int n = 0; n < 24; n++) begin
      rw   = int'($urandom % 2);
      nb   = int'($urandom_range(0, 3));
      r    = int'($urandom_range(0, 8));
      addr = (r < 6) ? r : 1015 + r;
      data = {$urandom, $urandom};
      hdr  = mk_hdr(rw[0], nb, int'($urandom % 4), addr);
`ifdef AD9361_SPI_RESP_MULTIBYTE_EN
      nbytes  = nb + 1;
      exp_err = 0;
`else
      nbytes  = 1;
      exp_err = (nb != 0) ? 1 : 0;
`endif
      exp_log.delete();
      exp_rx.delete();
      for (int k = 0; k < nbytes; k++) begin
        a   = (addr - k) & 1023;
        a10 = a[9:0];
        b   = data[63-8*k -: 8];
        if (rw != 0) begin
          exp_log.push_back({a10, b});
          ref_mem[a] = b;
        end else begin
          exp_rx.push_back(ref_mem[a]);
        end
      end
      exp_wr = (rw != 0) ? nbytes : 0;
      exp_rd = (rw != 0) ? 0 : nbytes;

      clr_mon();
      spi_bits(mk_frame(hdr, data), 16 + 8 * (nb + 1), 1'b1, rx);

      tests_run++;
      if (wr_cnt !== exp_wr || rd_cnt !== exp_rd || err_cnt !== exp_err) begin
        tests_failed++;
        $display("FAIL rand%0d_strobes: wr %0d rd %0d err %0d expected %0d %0d %0d",
                 n, wr_cnt, rd_cnt, err_cnt, exp_wr, exp_rd, exp_err);
      end
      for (int k = 0; k < exp_log.size(); k++) begin
        got = (k < wr_log.size()) ? wr_log[k] : 18'bx;
        tests_run++;
        if (got !== exp_log[k]) begin
          tests_failed++;
          $display("FAIL rand%0d_wr%0d: got addr %h data %h expected addr %h data %h",
                   n, k, got[17:8], got[7:0], exp_log[k][17:8], exp_log[k][7:0]);
        end
      end
      for (int k = 0; k < exp_rx.size(); k++) begin
        tests_run++;
        if (rx[111-8*k -: 8] !== exp_rx[k]) begin
          tests_failed++;
          $display("FAIL rand%0d_rd%0d: got %h expected %h", n, k, rx[111-8*k -: 8], exp_rx[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [127:0] rx;
    logic [17:0]  got;
    clr_mon();
    spi_bits({24'h812399, 104'h0}, 20, 1'b0, rx);
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk_200);
    tests_run++;
    if (wr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_write: wr pulses %0d expected 0", wr_cnt);
    end
    tests_run++;
    if ({spi.spi_miso, spi.spi_miso_oe, wr_stb, rd_stb, frame_err} !== 5'b0 ||
        wr_addr !== 10'h000 || wr_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: miso %b oe %b wr %b rd %b err %b addr %h data %h expected all 0",
               spi.spi_miso, spi.spi_miso_oe, wr_stb, rd_stb, frame_err, wr_addr, wr_data);
    end
    spi.spi_csn = 1'b1;
    spi.spi_clk = 1'b0;
    repeat (4) @(negedge sys_clk_200);
    sys_rst = 1'b0;
    repeat (8) @(negedge sys_clk_200);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    clr_mon();
    spi_bits({24'h000100, 104'h0}, 24, 1'b1, rx);
    tests_run++;
    if (rx[111:104] !== ref_mem[10'h001]) begin
      tests_failed++;
      $display("FAIL rst_regfile_cleared: got %h expected %h", rx[111:104], ref_mem[10'h001]);
    end

    clr_mon();
    spi_bits({24'h812399, 104'h0}, 24, 1'b1, rx);
    ref_mem[10'h123] = 8'h99;
    got = (wr_log.size() > 0) ? wr_log[0] : 18'bx;
    tests_run++;
    if (wr_cnt !== 1 || got !== {10'h123, 8'h99}) begin
      tests_failed++;
      $display("FAIL rst_resync_write: wr %0d addr %h data %h expected 1 123 99", wr_cnt, got[17:8], got[7:0]);
    end
    spi_bits({24'h012300, 104'h0}, 24, 1'b1, rx);
    tests_run++;
    if (rx[111:104] !== 8'h99) begin
      tests_failed++;
      $display("FAIL rst_resync_read: got %h expected 99", rx[111:104]);
    end
  endtask

  task automatic test_strobe_protocol;
    tests_run++;
    if (viol_cnt !== 0) begin
      tests_failed++;
      $display("FAIL strobe_exclusive: %0d overlapping or stretched pulses expected 0", viol_cnt);
    end
  endtask

  initial begin
    viol_cnt = 0;
    clr_mon();
    test_reset();
    test_write_read();
    test_abort();
    test_multibyte();
    test_random();
    test_reset_mid_frame();
    test_strobe_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
